// File: rtl/next_address_unit_if.sv
// rtl/next_address_unit_if.sv - control/flag inputs and PC/RAS status outputs of the next-address unit
interface next_address_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int BR_OFF_W  = 16,
    parameter int JMP_W     = 26,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic                advance;
    logic [2:0]          sel;
    logic [2:0]          brtype;
    logic                zero_flag;
    logic                carry_flag;
    logic                msb;
    logic [BR_OFF_W-1:0] branch_label;
    logic [JMP_W-1:0]    jmp_label;
    logic [ADDR_W-1:0]   jmp_ra;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   next_pc;
    logic                taken;
    logic [CNT_W-1:0]    ras_count;
    logic                ras_overflow;
    logic                ras_underflow;

    modport master (
        output advance, sel, brtype, zero_flag, carry_flag, msb,
               branch_label, jmp_label, jmp_ra,
        input  pc, next_pc, taken, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  advance, sel, brtype, zero_flag, carry_flag, msb,
               branch_label, jmp_label, jmp_ra,
        output pc, next_pc, taken, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/next_address_unit.sv
// rtl/next_address_unit.sv - registered PC with branch/jump/call/return selection and circular RAS
module next_address_unit #(
    parameter int                       ADDR_W    = 32,
    parameter int                       BR_OFF_W  = 16,
    parameter int                       JMP_W     = 26,
    parameter int                       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]        RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    next_address_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic              taken_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  top_q;
    logic              ovf_q;
    logic              udf_q;
    logic [ADDR_W-1:0] stack [RAS_DEPTH];

    logic [ADDR_W-1:0] pc1;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] nxt;
    logic              cond;
    logic              tk;
    logic              push;
    logic              pop;
    logic              udf_hit;
    logic              ras_full;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;

    assign pc1      = pc_q + ADDR_W'(1);
    assign br_off   = ADDR_W'($signed(bus.branch_label));
    assign ras_full = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_inc  = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
    assign top_dec  = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

    always_comb begin
        cond = 1'b0;
        case (bus.brtype)
            3'd0:    cond = 1'b1;
            3'd1:    cond = bus.zero_flag;
            3'd2:    cond = !bus.zero_flag;
            3'd3:    cond = bus.carry_flag;
            3'd4:    cond = !bus.carry_flag;
            3'd5:    cond = bus.msb;
            3'd6:    cond = !bus.msb;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        nxt     = pc1;
        tk      = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        udf_hit = 1'b0;
        case (bus.sel)
            3'd1: begin
                if (cond) begin
                    nxt = pc1 + br_off;
                    tk  = 1'b1;
                end
            end
            3'd2: begin
                nxt = ADDR_W'(bus.jmp_label);
                tk  = 1'b1;
            end
            3'd3: begin
                nxt = bus.jmp_ra;
                tk  = 1'b1;
            end
            3'd4: begin
                nxt  = ADDR_W'(bus.jmp_label);
                tk   = 1'b1;
                push = 1'b1;
            end
            3'd5: begin
                tk = 1'b1;
                // An empty stack falls back to the register target instead of stale data
                if (cnt_q != '0) begin
                    nxt = stack[top_q];
                    pop = 1'b1;
                end else begin
                    nxt     = bus.jmp_ra;
                    udf_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (bus.advance) begin
            pc_q    <= nxt;
            taken_q <= tk;
            if (push) begin
                top_q <= top_inc;
                if (ras_full) ovf_q <= 1'b1;
                else          cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop) begin
                top_q <= top_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (udf_hit) udf_q <= 1'b1;
        end
    end

    // Stack contents need no reset; when full the push lands on the oldest slot
    always_ff @(posedge clk) begin
        if (bus.advance && push) stack[top_inc] <= pc1;
    end

    assign bus.pc            = pc_q;
    assign bus.next_pc       = nxt;
    assign bus.taken         = taken_q;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = udf_q;
endmodule
